inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream from the UART receiver and assembles it into 32-bit words.
- Each word is written into the instruction RAM through a single write port.
- Holds the CPU while a load is in progress, then releases it so the processor fetches the new image from address 0.
- Lets a program be replaced without resynthesis.

Parameters:
- ROM_SIZE, 256: number of 32-bit words in the instruction memory. Word counts above this are rejected.
- TIMEOUT, 1000000: maximum clk cycles allowed between accepted bytes while a frame is open.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle. May be asserted every cycle.
- rx_data  input  8  received byte
- wr_en  output  1  instruction memory write enable, one cycle per word
- wr_addr  output  32  byte address of the word, word-aligned (bits [1:0]=0), bit 31=0
- wr_data  output  32  word to write
- cpu_hold  output  1  1 = CPU stalled/held in reset by top level
- load_done  output  1  one-cycle pulse when a frame completes with a good checksum
- load_error  output  1  sticky error flag
- words_loaded  output  16  words written in the current or last frame

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs to 0 and the state to IDLE.
  - All internal counters, the accumulator and the checksum clear.
  - cpu_hold=0, so the CPU runs the existing image.
- Frame format: 0xA5, N[15:8], N[7:0], then 4N data bytes, then CK.
  - Each word is sent MSB first.
  - CK is the XOR of the 4N data bytes only; header bytes are excluded.
- States: IDLE, CNT_HI, CNT_LO, DATA, CKSUM. Transitions occur only on cycles with rx_valid=1, except for timeout.
- IDLE
  - Bytes other than 0xA5 are ignored.
  - On 0xA5, in the next cycle: cpu_hold=1, load_error=0, words_loaded=0, checksum=0, byte index=0, word index=0. Go to CNT_HI.
- CNT_HI: store N[15:8], go to CNT_LO.
- CNT_LO: store N[7:0].
  - N==0 or N>ROM_SIZE: load_error=1, go to IDLE. cpu_hold stays 1.
  - Otherwise go to DATA.
- DATA
  - Shift each byte into the accumulator MSB-first and XOR it into the checksum.
  - On the 4th byte of a word, in the next cycle: wr_en=1 for exactly one cycle, wr_data=assembled word, wr_addr=word_index<<2.
  - In that same cycle words_loaded increments and word_index increments.
  - After word N-1 is accepted, go to CKSUM.
  - Back-to-back bytes at one per cycle must produce correct writes with no drops.
- CKSUM
  - Match: the next cycle gives load_done=1 for one cycle and cpu_hold=0. Go to IDLE.
  - Mismatch: load_error=1, cpu_hold stays 1, go to IDLE.
  - Words already written are not rolled back.
- Timeout
  - An idle counter resets on every rx_valid and counts only outside IDLE.
  - When it reaches TIMEOUT-1: load_error=1, go to IDLE, cpu_hold stays 1.
- Hold after a failed load: cpu_hold=1 is released only by a later successful frame or by reset. The CPU never runs a partial image.
- 0xA5 received outside IDLE is treated as ordinary data or count; there is no resynchronisation mid-frame.
- wr_addr and wr_data are held stable between writes. wr_en is never asserted outside DATA completion.
- Reset asserted mid-frame aborts the frame immediately. No further writes occur and cpu_hold=0.

Test Plan:
- Two-word load, back-to-back: A5 00 02 08 00 00 03 3C 08 40 00 7F.
  - Writes (addr 0x0, 0x08000003), then (0x4, 0x3C084000), each with a one-cycle wr_en.
  - Then load_done pulses, cpu_hold falls, words_loaded=2, load_error=0.
- Same frame with CK=0x7E: both writes occur; load_error=1, cpu_hold stays 1, no load_done.
- Count checks:
  - A5 01 01 (N=257 > 256): load_error=1, no writes, state back to IDLE.
  - A5 00 00: same result.
- Timeout: A5 00 01 08 00 followed by silence for TIMEOUT cycles.
  - load_error=1 and no write.
  - A following valid one-word frame then loads with load_error cleared at A5.
- Noise: bytes 00 FF 12 sent in IDLE produce no state change and cpu_hold=0; a subsequent valid frame loads normally.
- Reset mid-frame: assert reset after 6 data bytes of an N=2 frame.
  - All outputs go to 0 immediately and no second write occurs.
  - After release, a full frame loads correctly at addresses 0x0 and 0x4.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: assembles a framed UART byte stream
// (A5, N hi, N lo, 4N data bytes MSB first, XOR checksum) into
// 32-bit words and writes them to the instruction RAM, holding the
// CPU until a frame completes with a good checksum.
// Ports: clk, reset (async active-low), rx_valid/rx_data byte strobe,
// wr_en/wr_addr/wr_data RAM write port, cpu_hold, load_done pulse,
// load_error sticky flag, words_loaded count of the current/last frame.
module inst_mem_loader #(
    parameter int ROM_SIZE = 256,
    parameter int TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [16:0] NMAX = 17'(ROM_SIZE);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, CKSUM
    } state_t;

    state_t        state, state_n;
    logic [7:0]    cnt_hi;
    logic [15:0]   count;
    logic [23:0]   acc;
    logic [7:0]    cksum;
    logic [1:0]    byte_idx;
    logic [TW-1:0] idle_cnt;

    logic [15:0] n_new;
    logic        start, cnt_bad, word_done, ck_ok, ck_bad, tmo;

    assign n_new = {cnt_hi, rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        cnt_bad   = 1'b0;
        word_done = 1'b0;
        ck_ok     = 1'b0;
        ck_bad    = 1'b0;
        tmo       = 1'b0;
        // Silence only expires an open frame; any byte restarts the count.
        if (state != IDLE && !rx_valid && idle_cnt == TMAX) begin
            tmo     = 1'b1;
            state_n = IDLE;
        end else if (rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == 8'hA5) begin
                        start   = 1'b1;
                        state_n = CNT_HI;
                    end
                end
                CNT_HI: state_n = CNT_LO;
                CNT_LO: begin
                    if (n_new == 16'd0 || {1'b0, n_new} > NMAX) begin
                        cnt_bad = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (byte_idx == 2'd3) begin
                        word_done = 1'b1;
                        if (words_loaded == count - 16'd1)
                            state_n = CKSUM;
                    end
                end
                CKSUM: begin
                    if (rx_data == cksum) ck_ok  = 1'b1;
                    else                  ck_bad = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       idle_cnt <= '0;
        else if (state == IDLE || rx_valid) idle_cnt <= '0;
        else if (idle_cnt != TMAX)        idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            cnt_hi       <= '0;
            count        <= '0;
            acc          <= '0;
            cksum        <= '0;
            byte_idx     <= '0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            if (start) begin
                cpu_hold     <= 1'b1;
                load_error   <= 1'b0;
                words_loaded <= '0;
                cksum        <= '0;
                byte_idx     <= '0;
            end
            if (rx_valid && state == CNT_HI) cnt_hi <= rx_data;
            if (rx_valid && state == CNT_LO) count  <= n_new;
            if (rx_valid && state == DATA) begin
                acc      <= {acc[15:0], rx_data};
                cksum    <= cksum ^ rx_data;
                byte_idx <= byte_idx + 2'd1;
            end
            if (word_done) begin
                wr_en        <= 1'b1;
                wr_data      <= {acc, rx_data};
                wr_addr      <= {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
            end
            if (cnt_bad || ck_bad || tmo) load_error <= 1'b1;
            if (ck_ok) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed frame table,
// hand-written timeout/reset sequences and randomized frame streams.
module tb_inst_mem_loader;

    localparam int ROM = 256;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    inst_mem_loader #(.ROM_SIZE(ROM), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    logic [63:0] cap[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (reset && wr_en) cap.push_back({wr_addr, wr_data});
        if (load_done) done_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_err", 64'(load_error), 64'd0);
        chk("rst_wl", 64'(words_loaded), 64'd0);
        chk("rst_wr", {wr_addr, wr_data}, 64'd0);
        chk("rst_en", 64'({wr_en, load_done}), 64'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    typedef struct packed {
        int           len;
        logic [127:0] bytes;
        int           nw;
        logic [63:0]  wa;
        logic [63:0]  wd;
        logic         err;
        logic         hold;
        int           done;
        int           wl;
    } vec_t;

    vec_t tv[5];

    task automatic setv(input int i, input int len, input logic [127:0] b,
                        input int nw, input logic [63:0] wa,
                        input logic [63:0] wd, input logic err,
                        input logic hold, input int done, input int wl);
        tv[i].len = len;   tv[i].bytes = b;
        tv[i].nw = nw;     tv[i].wa = wa;   tv[i].wd = wd;
        tv[i].err = err;   tv[i].hold = hold;
        tv[i].done = done; tv[i].wl = wl;
    endtask

    // Reference model: frame-level parse of a complete byte stream.
    logic [7:0]  stream[$];
    int          gaps[$];
    logic [63:0] exp_w[$];
    logic        m_err, m_hold;
    int          m_done, m_wl;

    task automatic run_model();
        int i;
        int n;
        logic [7:0] ck;
        logic [31:0] word;
        i = 0;
        exp_w.delete();
        m_err = 0; m_hold = 0; m_done = 0; m_wl = 0;
        while (i < stream.size()) begin
            if (stream[i] != 8'hA5) begin
                i++;
                continue;
            end
            m_hold = 1; m_err = 0; m_wl = 0;
            n = int'({stream[i+1], stream[i+2]});
            i += 3;
            if (n == 0 || n > ROM) begin
                m_err = 1;
                continue;
            end
            ck = 8'h00;
            for (int w = 0; w < n; w++) begin
                word = {stream[i+4*w], stream[i+4*w+1],
                        stream[i+4*w+2], stream[i+4*w+3]};
                ck ^= word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
                exp_w.push_back({32'(w * 4), word});
                m_wl++;
            end
            i += 4 * n;
            if (stream[i] == ck) begin
                m_done++;
                m_hold = 0;
            end else begin
                m_err = 1;
            end
            i++;
        end
    endtask

    task automatic push_b(input logic [7:0] b);
        stream.push_back(b);
        gaps.push_back((($urandom_range(0, 3)) == 0) ?
                       int'($urandom_range(1, 5)) : 0);
    endtask

    initial begin
        int wb;
        int db;
        int n;
        logic [7:0] b;
        logic [7:0] ck;

        setv(0, 12, 128'hA5000208_0000033C_0840007F_00000000, 2,
             {32'h0, 32'h4}, {32'h08000003, 32'h3C084000}, 0, 0, 1, 2);
        setv(1, 12, 128'hA5000208_0000033C_0840007E_00000000, 2,
             {32'h0, 32'h4}, {32'h08000003, 32'h3C084000}, 1, 1, 0, 2);
        setv(2, 3, 128'hA50101_00_00000000_00000000_00000000, 0,
             64'd0, 64'd0, 1, 1, 0, 0);
        setv(3, 3, 128'hA50000_00_00000000_00000000_00000000, 0,
             64'd0, 64'd0, 1, 1, 0, 0);
        setv(4, 11, 128'h00FF12A5_0001DEAD_BEEF2200_00000000, 1,
             {32'h0, 32'h0}, {32'hDEADBEEF, 32'h0}, 0, 0, 1, 1);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            wb = cap.size();
            db = done_cnt;
            for (int k = 0; k < tv[i].len; k++)
                send(tv[i].bytes[127-8*k -: 8]);
            idle(4);
            chk($sformatf("v%0d_nw", i), 64'(cap.size() - wb),
                64'(tv[i].nw));
            for (int k = 0; k < tv[i].nw; k++)
                if (cap.size() - wb > k)
                    chk($sformatf("v%0d_w%0d", i, k), cap[wb+k],
                        {tv[i].wa[63-32*k -: 32], tv[i].wd[63-32*k -: 32]});
            chk($sformatf("v%0d_err", i), 64'(load_error), 64'(tv[i].err));
            chk($sformatf("v%0d_hold", i), 64'(cpu_hold), 64'(tv[i].hold));
            chk($sformatf("v%0d_done", i), 64'(done_cnt - db),
                64'(tv[i].done));
            chk($sformatf("v%0d_wl", i), 64'(words_loaded), 64'(tv[i].wl));
        end

        // Noise in IDLE leaves everything untouched.
        do_reset();
        wb = cap.size();
        send(8'h00); send(8'hFF); send(8'h12);
        idle(3);
        chk("noise_hold", 64'(cpu_hold), 64'd0);
        chk("noise_err", 64'(load_error), 64'd0);
        chk("noise_nw", 64'(cap.size() - wb), 64'd0);

        // Timeout mid-word, then a good one-word frame.
        do_reset();
        wb = cap.size();
        db = done_cnt;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h08); send(8'h00);
        idle(TMO + 5);
        chk("tmo_err", 64'(load_error), 64'd1);
        chk("tmo_hold", 64'(cpu_hold), 64'd1);
        chk("tmo_nw", 64'(cap.size() - wb), 64'd0);
        send(8'hA5);
        idle(1);
        chk("tmo_a5_err", 64'(load_error), 64'd0);
        send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h44);
        idle(4);
        chk("tmo2_nw", 64'(cap.size() - wb), 64'd1);
        if (cap.size() - wb > 0)
            chk("tmo2_w", cap[wb], {32'h0, 32'h11223344});
        chk("tmo2_done", 64'(done_cnt - db), 64'd1);
        chk("tmo2_hold", 64'(cpu_hold), 64'd0);
        chk("tmo2_err", 64'(load_error), 64'd0);

        // Reset after six data bytes of a two-word frame.
        do_reset();
        wb = cap.size();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h08); send(8'h00); send(8'h00); send(8'h03);
        send(8'h3C); send(8'h08);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mid_out", {wr_addr, wr_data}, 64'd0);
        chk("mid_flags", 64'({wr_en, cpu_hold, load_done, load_error}),
            64'd0);
        chk("mid_wl", 64'(words_loaded), 64'd0);
        idle(3);
        reset = 1'b1;
        idle(5);
        chk("mid_nw", 64'(cap.size() - wb), 64'd1);
        for (int k = 0; k < 12; k++)
            send(tv[0].bytes[127-8*k -: 8]);
        idle(4);
        chk("mid2_nw", 64'(cap.size() - wb), 64'd3);
        if (cap.size() - wb > 2) begin
            chk("mid2_w0", cap[wb+1], {32'h0, 32'h08000003});
            chk("mid2_w1", cap[wb+2], {32'h4, 32'h3C084000});
        end
        chk("mid2_hold", 64'(cpu_hold), 64'd0);

        // Randomized frame streams against the reference model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            wb = cap.size();
            db = done_cnt;
            stream.delete();
            gaps.delete();
            for (int f = 0; f < 6; f++) begin
                repeat ($urandom_range(0, 2)) begin
                    b = 8'($urandom);
                    push_b((b == 8'hA5) ? 8'h00 : b);
                end
                push_b(8'hA5);
                if ($urandom_range(0, 7) == 0) begin
                    n = ($urandom_range(0, 1) == 0) ? 0 : ROM + 1;
                    push_b(8'(n >> 8));
                    push_b(8'(n));
                    continue;
                end
                n = $urandom_range(1, 4);
                push_b(8'(n >> 8));
                push_b(8'(n));
                ck = 8'h00;
                for (int k = 0; k < 4 * n; k++) begin
                    b = 8'($urandom);
                    ck ^= b;
                    push_b(b);
                end
                if ($urandom_range(0, 3) == 0)
                    ck ^= 8'($urandom_range(1, 255));
                push_b(ck);
            end
            for (int k = 0; k < stream.size(); k++) begin
                send(stream[k]);
                if (gaps[k] > 0) idle(gaps[k]);
            end
            idle(4);
            run_model();
            chk($sformatf("r%0d_nw", r), 64'(cap.size() - wb),
                64'(exp_w.size()));
            for (int k = 0; k < exp_w.size(); k++)
                if (cap.size() - wb > k)
                    chk($sformatf("r%0d_w%0d", r, k), cap[wb+k], exp_w[k]);
            chk($sformatf("r%0d_done", r), 64'(done_cnt - db), 64'(m_done));
            chk($sformatf("r%0d_err", r), 64'(load_error), 64'(m_err));
            chk($sformatf("r%0d_hold", r), 64'(cpu_hold), 64'(m_hold));
            chk($sformatf("r%0d_wl", r), 64'(words_loaded), 64'(m_wl));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
